pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Drives PC and IF/ID enables plus IF/ID and ID/EX flushes; selects EX-operand forwarding from MEM/WB.
//  Owns the multi-cycle MULT/DIV busy window (RUN/MDU_BUSY FSM with latency counter).
//  Sits beside the stage registers; consumes their register-number/control fields only.
// PARAMETERS
//  MDU_LATENCY  32  cycles from MDU start in EX until HI/LO valid (>=2)
//  CNT_W        6   width of MDU down-counter; must hold MDU_LATENCY
// PORTS
//  clock          in   1  rising-edge clock
//  reset          in   1  asynchronous, active-high
//  id_rs, id_rt   in   5  source regs of instruction in ID
//  id_uses_rs/rt  in   1  ID instruction actually reads rs / rt
//  id_reads_hilo  in   1  ID instruction is MFHI/MFLO
//  id_is_mdu      in   1  ID instruction is MULT/MULTU/DIV/DIVU
//  ex_rs, ex_rt   in   5  source regs of instruction in EX
//  ex_reg_write   in   1  EX RegWrite;  ex_mem_read in 1: EX is a load
//  ex_write_reg   in   5  EX destination reg
//  ex_mdu_start   in   1  MDU op is in EX this cycle (starts unit)
//  ex_pc_src      in   3  EX PCSrc; nonzero = redirect (branch taken/jump)
//  me_reg_write   in   1  MEM RegWrite;  me_write_reg in 5
//  wb_reg_write   in   1  WB RegWrite;   wb_write_reg in 5
//  pc_en          out  1  PC update enable
//  ifid_en        out  1  IF/ID register enable
//  ifid_flush     out  1  IF/ID clear to bubble
//  idex_flush     out  1  ID/EX clear to bubble
//  fwd_a, fwd_b   out  2  EX operand select: 00 regfile, 10 MEM ALU result, 01 WB result
//  mdu_busy       out  1  FSM in MDU_BUSY
// BEHAVIOUR
//  - Reset (async): state=RUN, counter=0, mdu_busy=0. Outputs are combinational from state+inputs:
//    with idle inputs pc_en=1, ifid_en=1, flushes=0, fwd=00.
//  - Load-use: ex_mem_read & ex_reg_write & ex_write_reg!=0 & match on used id_rs/id_rt
//    -> pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble; resolved via WB forward next-next cycle.
//  - HI/LO stall: state MDU_BUSY & (id_reads_hilo | id_is_mdu) -> same stall pattern as load-use.
//  - Redirect: ex_pc_src!=0 -> ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1.
//    Redirect overrides any stall in the same cycle (stalled instruction is on wrong path).
//  - FSM: RUN --ex_mdu_start--> MDU_BUSY, counter<=MDU_LATENCY-1.
//    MDU_BUSY: counter decrements each cycle; at counter==0 -> RUN.
//    ex_mdu_start while MDU_BUSY cannot occur (blocked by stall); if asserted, it is ignored.
//  - Counter saturates at 0, never wraps. Reset mid-busy returns to RUN at once; stalls drop.
//  - Forwarding, per operand (src = ex_rs / ex_rt):
//    10 if me_reg_write & me_write_reg==src & src!=0; else 01 if wb_reg_write & wb_write_reg==src & src!=0; else 00.
//    MEM takes priority over WB. Register $0 is never forwarded.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
//    Counts cycles with pc_en=0 and cycles with ifid_flush=1. Async clear on reset; wrap at 2^32.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package/header pipe_pkg: FWD_RF/FWD_MEM/FWD_WB codes, FSM state encodings S_RUN/S_MDU_BUSY, REG_ZERO.
//  One sub-module: hazard_fwd_unit (purely combinational forwarding compare), instantiated for A and B.
//  FSM, counter, stall/flush logic and perf counters stay in the top module.
// TESTING
//  1. Reset asserted mid-cycle, then released -> pc_en=1, ifid_en=1, flushes=0, fwd=00, mdu_busy=0.
//  2. Load in EX: ex_mem_read=1, ex_write_reg=8; ID uses id_rs=8
//     -> one cycle pc_en=0/ifid_en=0/idex_flush=1; next cycle no stall.
//  3. me_write_reg=9, wb_write_reg=9, ex_rs=9, both RegWrite=1 -> fwd_a=10.
//     Then me_reg_write=0 -> fwd_a=01. With ex_rs=0 -> fwd_a=00.
//  4. MDU_LATENCY=4, ex_mdu_start pulse, then MFLO in ID
//     -> mdu_busy=1 for exactly 4 cycles, stall for those cycles, release on 5th.
//  5. Load-use stall and ex_pc_src=3'b001 in same cycle -> pc_en=1, ifid_flush=1, idex_flush=1.
//  6. Reset during MDU_BUSY (counter=10) -> immediately RUN, mdu_busy=0.
//     With PIPE_HAZARD_PERF_EN: perf counts return to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller: forwarding
// select codes, hazard FSM state encodings and the hard-wired zero register.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MDU_BUSY = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-operand forwarding select for one source register.
// MEM result wins over WB result; $0 is never forwarded.
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       me_reg_write,
  input  logic [4:0] me_write_reg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_reg,
  output logic [1:0] fwd_sel
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the output
    // unassigned, which would infer a latch.
    fwd_sel = FWD_RF;
    if (src != REG_ZERO) begin
      if (me_reg_write && (me_write_reg == src)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_reg_write && (wb_write_reg == src)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use and HI/LO stalls, redirect flushes,
// forwarding selects and the MULT/DIV busy window. Optional perf counters via PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_reads_hilo,
  input  logic       id_is_mdu,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic       ex_mdu_start,
  input  logic [2:0] ex_pc_src,
  input  logic       me_reg_write,
  input  logic [4:0] me_write_reg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_reg,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mdu_busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic hilo_stall;
  logic stall;
  logic redirect;

  // MULT/DIV busy window: the counter holds the remaining busy cycles minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (ex_mdu_start) begin
          state_d = S_MDU_BUSY;
          cnt_d   = CNT_W'(MDU_LATENCY - 1);
        end
      end
      S_MDU_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdu_busy = (state_q == S_MDU_BUSY);

  always_comb begin
    load_use = 1'b0;
    if (ex_mem_read && ex_reg_write && (ex_write_reg != REG_ZERO)) begin
      load_use = (id_uses_rs && (id_rs == ex_write_reg)) ||
                 (id_uses_rt && (id_rt == ex_write_reg));
    end
  end

  assign hilo_stall = mdu_busy && (id_reads_hilo || id_is_mdu);
  assign stall      = load_use || hilo_stall;
  assign redirect   = (ex_pc_src != 3'b000);

  // A redirect squashes the stalled ID instruction, so it overrides the stall.
  assign pc_en      = redirect || !stall;
  assign ifid_en    = redirect || !stall;
  assign ifid_flush = redirect;
  assign idex_flush = redirect || stall;

  hazard_fwd_unit u_fwd_a (
    .src          (ex_rs),
    .me_reg_write (me_reg_write),
    .me_write_reg (me_write_reg),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .fwd_sel      (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .src          (ex_rt),
    .me_reg_write (me_reg_write),
    .me_write_reg (me_write_reg),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .fwd_sel      (fwd_b)
  );

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + (pc_en ? 32'd0 : 32'd1);
    perf_flush_d = perf_flush_q + (ifid_flush ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controllers (MDU latency 4 and 16) on shared inputs,
// compared against a remaining-busy-cycles reference model; directed cases then random traffic.
module tb_pipeline_hazard_ctrl;

  localparam int LAT_S = 4;
  localparam int LAT_L = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, me_write_reg, wb_write_reg;
  logic       id_uses_rs, id_uses_rt, id_reads_hilo, id_is_mdu;
  logic       ex_reg_write, ex_mem_read, ex_mdu_start, me_reg_write, wb_reg_write;
  logic [2:0] ex_pc_src;

  logic       pc_en_s, ifid_en_s, ifid_flush_s, idex_flush_s, busy_s;
  logic       pc_en_l, ifid_en_l, ifid_flush_l, idex_flush_l, busy_l;
  logic [1:0] fwd_a_s, fwd_b_s, fwd_a_l, fwd_b_l;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] pstall_s, pflush_s, pstall_l, pflush_l;
  int unsigned m_pstall_s, m_pflush_s, m_pstall_l, m_pflush_l;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rem_s = 0;  // model: cycles of MDU busy still ahead, short-latency unit
  int rem_l = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MDU_LATENCY(LAT_S), .CNT_W(6)) dut_s (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reads_hilo(id_reads_hilo), .id_is_mdu(id_is_mdu),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_mdu_start(ex_mdu_start), .ex_pc_src(ex_pc_src),
    .me_reg_write(me_reg_write), .me_write_reg(me_write_reg),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .pc_en(pc_en_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .mdu_busy(busy_s)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cnt(pstall_s), .perf_flush_cnt(pflush_s)
`endif
  );

  pipeline_hazard_ctrl #(.MDU_LATENCY(LAT_L), .CNT_W(6)) dut_l (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reads_hilo(id_reads_hilo), .id_is_mdu(id_is_mdu),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_mdu_start(ex_mdu_start), .ex_pc_src(ex_pc_src),
    .me_reg_write(me_reg_write), .me_write_reg(me_write_reg),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .pc_en(pc_en_l), .ifid_en(ifid_en_l), .ifid_flush(ifid_flush_l), .idex_flush(idex_flush_l),
    .fwd_a(fwd_a_l), .fwd_b(fwd_b_l), .mdu_busy(busy_l)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cnt(pstall_l), .perf_flush_cnt(pflush_l)
`endif
  );

  typedef struct packed {
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       busy;
  } outs_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (me_reg_write && me_write_reg == src) return 2'b10;
    if (wb_reg_write && wb_write_reg == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outs_t model(input int rem);
    outs_t o;
    logic  load_use, hilo, redir, stall;
    load_use = ex_mem_read && ex_reg_write && ex_write_reg != 5'd0 &&
               ((id_uses_rs && id_rs == ex_write_reg) || (id_uses_rt && id_rt == ex_write_reg));
    hilo  = (rem > 0) && (id_reads_hilo || id_is_mdu);
    redir = (ex_pc_src != 3'd0);
    stall = (load_use || hilo) && !redir;
    o.pc_en      = !stall;
    o.ifid_en    = !stall;
    o.ifid_flush = redir;
    o.idex_flush = redir || load_use || hilo;
    o.fwd_a      = fwd_of(ex_rs);
    o.fwd_b      = fwd_of(ex_rt);
    o.busy       = (rem > 0);
    return o;
  endfunction

  task automatic check_all();
    outs_t es, el;
    es = model(rem_s);
    el = model(rem_l);
    check("s.pc_en", pc_en_s, es.pc_en);
    check("s.ifid_en", ifid_en_s, es.ifid_en);
    check("s.ifid_flush", ifid_flush_s, es.ifid_flush);
    check("s.idex_flush", idex_flush_s, es.idex_flush);
    check("s.fwd_a", fwd_a_s, es.fwd_a);
    check("s.fwd_b", fwd_b_s, es.fwd_b);
    check("s.mdu_busy", busy_s, es.busy);
    check("l.pc_en", pc_en_l, el.pc_en);
    check("l.idex_flush", idex_flush_l, el.idex_flush);
    check("l.mdu_busy", busy_l, el.busy);
`ifdef PIPE_HAZARD_PERF_EN
    check("s.perf_stall", pstall_s, m_pstall_s);
    check("s.perf_flush", pflush_s, m_pflush_s);
    check("l.perf_stall", pstall_l, m_pstall_l);
    check("l.perf_flush", pflush_l, m_pflush_l);
`endif
  endtask

  function automatic int next_rem(input int rem, input int lat);
    if (rem > 0) return rem - 1;
    if (ex_mdu_start) return lat;
    return 0;
  endfunction

  // Check the current cycle, then advance the model across the next rising edge.
  task automatic step();
    outs_t es, el;
    #1;
    check_all();
    es = model(rem_s);
    el = model(rem_l);
    @(posedge clock);
    if (!reset) begin
`ifdef PIPE_HAZARD_PERF_EN
      m_pstall_s += es.pc_en ? 0 : 1;
      m_pflush_s += es.ifid_flush ? 1 : 0;
      m_pstall_l += el.pc_en ? 0 : 1;
      m_pflush_l += el.ifid_flush ? 1 : 0;
`endif
      rem_s = next_rem(rem_s, LAT_S);
      rem_l = next_rem(rem_l, LAT_L);
    end
    #1;
  endtask

  task automatic model_reset();
    rem_s = 0;
    rem_l = 0;
`ifdef PIPE_HAZARD_PERF_EN
    m_pstall_s = 0; m_pflush_s = 0; m_pstall_l = 0; m_pflush_l = 0;
`endif
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_is_mdu = 0;
    ex_rs = 0; ex_rt = 0; ex_reg_write = 0; ex_mem_read = 0; ex_write_reg = 0;
    ex_mdu_start = 0; ex_pc_src = 0;
    me_reg_write = 0; me_write_reg = 0; wb_reg_write = 0; wb_write_reg = 0;
  endtask

  initial begin
    int busy_len;
    idle();
    model_reset();
    reset = 1'b1;

    // Reset released mid-cycle: everything idle
    #12 reset = 1'b0;
    step();
    check("rst.pc_en", pc_en_s, 1'b1);
    check("rst.mdu_busy", busy_s, 1'b0);

    // Load-use: exactly one bubble
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    #1 check("lu.pc_en", pc_en_s, 1'b0);
    step();
    idle();
    step();

    // Forwarding priority and $0
    me_reg_write = 1; wb_reg_write = 1; me_write_reg = 5'd9; wb_write_reg = 5'd9; ex_rs = 5'd9;
    #1 check("fwd.mem", fwd_a_s, 2'b10);
    step();
    me_reg_write = 0;
    #1 check("fwd.wb", fwd_a_s, 2'b01);
    step();
    ex_rs = 5'd0;
    step();
    idle();

    // MDU busy window with MFLO waiting in ID
    ex_mdu_start = 1;
    step();
    ex_mdu_start = 0; id_reads_hilo = 1;
    busy_len = 0;
    for (int i = 0; i < LAT_S + 2; i++) begin
      #1 if (busy_s) busy_len++;
      step();
    end
    check("mdu.busy_len", busy_len, LAT_S);
    idle();
    while (rem_l > 0) step();

    // Redirect overrides a load-use stall
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 5'd5; id_rt = 5'd5; id_uses_rt = 1;
    ex_pc_src = 3'b001;
    #1 check("redir.pc_en", pc_en_s, 1'b1);
    step();
    idle();

    // Reset while the long unit has 10 on its counter
    ex_mdu_start = 1;
    step();
    ex_mdu_start = 0; id_is_mdu = 1;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst.busy_l", busy_l, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1 check("midrst.busy_l", busy_l, 1'b0);
    check("midrst.pc_en_l", pc_en_l, 1'b1);
`ifdef PIPE_HAZARD_PERF_EN
    check("midrst.perf_stall_l", pstall_l, 32'd0);
`endif
    step();
    reset = 1'b0;
    idle();
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_reads_hilo = ($urandom_range(0, 3) == 0); id_is_mdu = ($urandom_range(0, 5) == 0);
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_write_reg = 5'($urandom_range(0, 3));
      ex_mdu_start = ($urandom_range(0, 11) == 0);
      ex_pc_src = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      me_reg_write = 1'($urandom); me_write_reg = 5'($urandom_range(0, 3));
      wb_reg_write = 1'($urandom); wb_write_reg = 5'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
